// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32 datapath: IDLE/FETCH/DECODE/EXEC/MEM/WB/ERR.
// One unified memory port is shared by instruction fetch and load/store (req/ack).
// All outputs are combinational decodes of the state register and the live inputs.
// Optional feature: define PERF_CNT_EN to add the retired/cycles counters.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 256,  // 0 disables the memory watchdog
  parameter int unsigned TO_W        = 9     // 2**TO_W must exceed MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic        Branch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        rf_we,
  output logic        busy,
  output logic        err
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] retired,
  output logic [31:0] cycles
`endif
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StErr
  } state_e;

  // Watchdog value seen on the last tolerated wait cycle.
  localparam logic [TO_W-1:0] WdogLast =
    TO_W'((MEM_TIMEOUT == 0) ? 0 : (MEM_TIMEOUT - 1));

  state_e          state_q, state_d;
  logic [TO_W-1:0] wdog_q, wdog_d;
  logic            mem_wait;
  logic            timeout;
  logic            legal_op;

  // Opcode legality: R-type, I-type ALU, load, store, branch.
  always_comb begin
    legal_op = 1'b0;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011: legal_op = 1'b1;
      default:                                                    legal_op = 1'b0;
    endcase
  end

  // Watchdog counts consecutive unacknowledged request cycles; ack beats timeout.
  always_comb begin
    mem_wait = ((state_q == StFetch) || (state_q == StMem)) && !mem_ack;
    timeout  = mem_wait && (MEM_TIMEOUT != 0) && (wdog_q == WdogLast);
    wdog_d   = mem_wait ? (wdog_q + 1'b1) : '0;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch: begin
        if (mem_ack)      state_d = StDecode;
        else if (timeout) state_d = StErr;
      end
      StDecode: state_d = legal_op ? StExec : StErr;
      StExec: begin
        if (Branch)                   state_d = StFetch;
        else if (MemRead || MemWrite) state_d = StMem;
        else                          state_d = StWb;
      end
      StMem: begin
        if (mem_ack)      state_d = MemWrite ? StFetch : StWb;
        else if (timeout) state_d = StErr;
      end
      StWb:     state_d = StFetch;
      StErr:    state_d = StErr;
      default:  state_d = StIdle;
    endcase
  end

  // State and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  // Output decode; reset forces StIdle so every output drops immediately.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    rf_we    = 1'b0;
    busy     = (state_q != StIdle) && (state_q != StErr);
    err      = (state_q == StErr);
    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
      end
      StExec: begin
        pc_we  = Branch;
        pc_sel = Branch && br_taken;
      end
      StMem: begin
        mem_req  = 1'b1;
        mem_we   = MemWrite;
        addr_sel = 1'b1;
        pc_we    = mem_ack && MemWrite;
      end
      StWb: begin
        rf_we = RegWrite;
        pc_we = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PERF_CNT_EN
  logic [31:0] retired_q, cycles_q;

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      if (pc_we) retired_q <= retired_q + 32'd1;
      if (busy)  cycles_q  <= cycles_q + 32'd1;
    end
  end

  assign retired = retired_q;
  assign cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded from its
// class into an expected per-cycle output trace, then replayed against the DUT.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] opcode;
  logic       Branch, MemRead, MemWrite, RegWrite, br_taken, mem_ack;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, busy, err;
`ifdef PERF_CNT_EN
  logic [31:0] retired, cycles;
`endif

  int total = 0;
  int bad   = 0;

  logic [8:0] outs;
  assign outs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, busy, err};

  multicycle_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opcode   (opcode),
    .Branch   (Branch),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .RegWrite (RegWrite),
    .br_taken (br_taken),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .addr_sel (addr_sel),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .pc_sel   (pc_sel),
    .rf_we    (rf_we),
    .busy     (busy),
    .err      (err)
`ifdef PERF_CNT_EN
    ,
    .retired  (retired),
    .cycles   (cycles)
`endif
  );

  always #5 clk = ~clk;

  // Instruction classes
  localparam int KAdd = 0, KAddi = 1, KLoad = 2, KStore = 3, KBr = 4, KIll = 5;

  function automatic logic [8:0] mk(input logic req, input logic we, input logic asel,
                                    input logic ir, input logic pc, input logic psel,
                                    input logic rf, input logic bz, input logic er);
    return {req, we, asel, ir, pc, psel, rf, bz, er};
  endfunction

  // Asynchronous reset pulse; outputs must drop without waiting for a clock edge.
  task automatic do_reset(input string name);
    start   = 1'b0;
    rst_n   = 1'b0;
    #2;
    total++;
    if (outs !== 9'b0) begin
      bad++;
      $display("FAIL %s: outputs in reset got %b want %b", name, outs, 9'b0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One IDLE cycle with start=1; the following cycle is FETCH.
  task automatic do_start(input string name);
    start   = 1'b1;
    mem_ack = 1'($urandom);
    @(negedge clk);
    total++;
    if (outs !== 9'b0) begin
      bad++;
      $display("FAIL %s: idle outputs got %b want %b", name, outs, 9'b0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs one instruction starting in FETCH; the class rules build the expected trace.
  task automatic run_instr(input int kind, input int fw, input int mw, input logic bt,
                           input logic rw, input string name);
    logic [8:0] exp_q[$];
    logic       ack_q[$];
    logic       is_br, is_ld, is_st;
    is_br = (kind == KBr);
    is_ld = (kind == KLoad);
    is_st = (kind == KStore);
    case (kind)
      KAdd:    opcode = 7'b0110011;
      KAddi:   opcode = 7'b0010011;
      KLoad:   opcode = 7'b0000011;
      KStore:  opcode = 7'b0100011;
      KBr:     opcode = 7'b1100011;
      default: opcode = 7'b1111111;
    endcase
    Branch   = is_br;
    MemRead  = is_ld;
    MemWrite = is_st;
    RegWrite = rw;
    br_taken = bt;
    if (kind == KIll) begin
      Branch = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
    end
    // start must be ignored everywhere outside IDLE
    start = (kind == KIll) ? 1'b1 : 1'($urandom);

    for (int i = 0; i < fw; i++) begin
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0)); ack_q.push_back(1'b0);
    end
    exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 0)); ack_q.push_back(1'b1);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); ack_q.push_back(1'($urandom));
    if (kind == KIll) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1)); ack_q.push_back(1'($urandom));
      end
    end else begin
      exp_q.push_back(mk(0, 0, 0, 0, is_br, is_br & bt, 0, 1, 0));
      ack_q.push_back(1'($urandom));
      if (is_ld || is_st) begin
        for (int i = 0; i < mw; i++) begin
          exp_q.push_back(mk(1, is_st, 1, 0, 0, 0, 0, 1, 0)); ack_q.push_back(1'b0);
        end
        exp_q.push_back(mk(1, is_st, 1, 0, is_st, 0, 0, 1, 0)); ack_q.push_back(1'b1);
      end
      if (!is_br && !is_st) begin
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, rw, 1, 0)); ack_q.push_back(1'($urandom));
      end
    end

    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ack = ack_q[i];
      @(negedge clk);
      total++;
      if (outs !== exp_q[i]) begin
        bad++;
        $display("FAIL %s cyc %0d: outs got %b want %b", name, i, outs, exp_q[i]);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    mem_ack = 1'b1;
    do_reset("reset");
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      total++;
      if (outs !== 9'b0) begin
        bad++;
        $display("FAIL reset_idle cyc %0d: got %b want %b", i, outs, 9'b0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_directed();
    do_reset("dir_reset");
    do_start("dir_start");
    run_instr(KAdd,   0, 0, 1'b0, 1'b1, "add_zero_wait");
    run_instr(KLoad,  2, 0, 1'b0, 1'b1, "lw_fetch_wait2");
    run_instr(KStore, 0, 1, 1'b0, 1'b1, "sw");
    run_instr(KBr,    0, 0, 1'b1, 1'b0, "beq_taken");
    run_instr(KBr,    0, 0, 1'b0, 1'b0, "beq_not_taken");
    run_instr(KAddi,  1, 0, 1'b0, 1'b0, "addi_rd0");
  endtask

  task automatic test_random();
    do_reset("rand_reset");
    do_start("rand_start");
    for (int n = 0; n < 40; n++) begin
      run_instr($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_illegal();
    do_reset("ill_reset");
    do_start("ill_start");
    run_instr(KAdd, 0, 0, 1'b0, 1'b1, "pre_ill");
    run_instr(KIll, 1, 0, 1'b0, 1'b0, "illegal_op");
  endtask

  // 256 unacknowledged fetch cycles are tolerated; the next cycle is ERR.
  task automatic test_timeout();
    do_reset("to_reset");
    do_start("to_start");
    mem_ack = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      total++;
      if (outs !== mk(1, 0, 0, 0, 0, 0, 0, 1, 0)) begin
        bad++;
        $display("FAIL timeout_wait cyc %0d: got %b want %b", i, outs,
                 mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
      end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b1;
    start   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (outs !== mk(0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
        bad++;
        $display("FAIL timeout_err cyc %0d: got %b want %b", i, outs,
                 mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    do_reset("mm_reset");
    do_start("mm_start");
    run_instr(KAdd, 0, 0, 1'b0, 1'b1, "mm_pre");
    opcode = 7'b0000011; Branch = 0; MemRead = 1; MemWrite = 0; RegWrite = 1;
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 0);  // FETCH ack, then DECODE, EXEC
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    #2;
    total++;
    if (outs !== mk(1, 0, 1, 0, 0, 0, 0, 1, 0)) begin
      bad++;
      $display("FAIL mid_mem_pre: got %b want %b", outs, mk(1, 0, 1, 0, 0, 0, 0, 1, 0));
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (outs !== 9'b0) begin
      bad++;
      $display("FAIL mid_mem_reset: got %b want %b", outs, 9'b0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (outs !== 9'b0) begin
      bad++;
      $display("FAIL mid_mem_idle: got %b want %b", outs, 9'b0);
    end
    @(posedge clk);
    #1;
    do_start("mm_restart");
    mem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== mk(1, 0, 0, 0, 0, 0, 0, 1, 0)) begin
      bad++;
      $display("FAIL mid_mem_refetch: got %b want %b", outs, mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    end
    @(posedge clk);
    #1;
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf();
    do_reset("perf_reset");
    total++;
    if (retired !== 32'd0 || cycles !== 32'd0) begin
      bad++;
      $display("FAIL perf_reset: got %0d/%0d want 0/0", retired, cycles);
    end
    do_start("perf_start");
    for (int i = 0; i < 3; i++) run_instr(KAdd, 0, 0, 1'b0, 1'b1, "perf_add");
    @(negedge clk);
    total++;
    if (retired !== 32'd3 || cycles !== 32'd12) begin
      bad++;
      $display("FAIL perf_counts: got retired=%0d cycles=%0d want 3/12", retired, cycles);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = '0; Branch = 0; MemRead = 0; MemWrite = 0;
    RegWrite = 0; br_taken = 0; mem_ack = 0;
    #12;
    test_reset();
    test_directed();
    test_random();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
`ifdef PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end want end");
    $fatal(1, "bench time limit");
  end

endmodule
